// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared constants and helpers for the byte-wide system RAM.
//               RAM_DATA_W     - width of one stored byte
//               RAM_DEFAULT_AW - default address width (128 KiB)
//               IO_SEL         - a[17:16] pattern the top level decodes as I/O
//               parity8()      - even-parity bit of one byte
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int         RAM_DATA_W     = 8;
    localparam int         RAM_DEFAULT_AW = 17;
    localparam logic [1:0] IO_SEL         = 2'b11;

    // XOR-reduction: 1 when the byte holds an odd number of ones.
    function automatic logic parity8(input logic [RAM_DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_parity_chk.sv
`default_nettype none
// ============================================================================
// Module      : ram_parity_chk
// Description : Combinational parity generate/compare for the RAM array.
//               Used by byte_ram only when RAM_PARITY_EN is defined.
// Ports       : i_wr_data   in  8  byte about to be written
//               o_wr_parity out 1  parity bit to store alongside it
//               i_rd_word   in  9  {stored_parity, stored_data} read back
//               o_rd_err    out 1  stored parity disagrees with the data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_parity_chk
    import ram_pkg::*;
(
    input  logic [RAM_DATA_W-1:0] i_wr_data,
    output logic                  o_wr_parity,
    input  logic [RAM_DATA_W:0]   i_rd_word,
    output logic                  o_rd_err
);

    assign o_wr_parity = parity8(i_wr_data);
    assign o_rd_err    = i_rd_word[RAM_DATA_W] ^ parity8(i_rd_word[RAM_DATA_W-1:0]);

endmodule : ram_parity_chk
`default_nettype wire

// File: rtl/byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_ram
// Description : Byte-wide single-port synchronous RAM (system memory).
//               One synchronous read port and one write port sharing a_in,
//               registered read data with 1-cycle latency. No address decode
//               is done here; the top level gates en_in for the I/O window.
//               Optional macro RAM_PARITY_EN widens the array to 9 bits and
//               reports a registered parity error aligned with d_out.
// Ports       : clk_in         in  1           rising-edge clock
//               rst_n_in       in  1           async active-low reset
//                                              (output registers only)
//               en_in          in  1           access enable
//               r_nw_in        in  1           1 = read, 0 = write
//               a_in           in  ADDR_WIDTH  byte address
//               d_in           in  8           write data
//               d_out          out 8           registered read data
//               parity_err_out out 1           registered parity error
// Revision    : 1.0 - initial release
// ============================================================================
module byte_ram
    import ram_pkg::*;
#(
    parameter int    ADDR_WIDTH = RAM_DEFAULT_AW,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_in,
    input  logic                  r_nw_in,
    input  logic [ADDR_WIDTH-1:0] a_in,
    input  logic [RAM_DATA_W-1:0] d_in,
    output logic [RAM_DATA_W-1:0] d_out,
    output logic                  parity_err_out
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int c_WORD_W = RAM_DATA_W + 1;
`else
    localparam int c_WORD_W = RAM_DATA_W;
`endif

    logic [c_WORD_W-1:0]   r_mem [c_DEPTH];
    logic [c_WORD_W-1:0]   w_wr_word;
    logic [c_WORD_W-1:0]   w_rd_word;
    logic [RAM_DATA_W-1:0] r_d_out;
    logic                  w_wr_en;
    logic                  w_rd_en;

    // Writes are suppressed while reset is held, even though the array
    // itself is never cleared.
    assign w_wr_en   = en_in & ~r_nw_in & rst_n_in;
    assign w_rd_en   = en_in &  r_nw_in;
    assign w_rd_word = r_mem[a_in];

`ifdef RAM_PARITY_EN
    logic w_wr_parity;
    logic w_rd_err;
    logic r_parity_err;

    ram_parity_chk u_parity_chk (
        .i_wr_data   (d_in),
        .o_wr_parity (w_wr_parity),
        .i_rd_word   (w_rd_word),
        .o_rd_err    (w_rd_err)
    );

    assign w_wr_word = {w_wr_parity, d_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_parity_err <= 1'b0;
        end else if (w_rd_en) begin
            r_parity_err <= w_rd_err;
        end
    end

    assign parity_err_out = r_parity_err;
`else
    assign w_wr_word      = d_in;
    assign parity_err_out = 1'b0;
`endif

    // Array write port: no reset, so the tools can map it onto block RAM.
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[a_in] <= w_wr_word;
        end
    end

    // Output register: updated only by reads, so writes and idle cycles
    // leave the last read byte visible (no write-through).
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_d_out <= '0;
        end else if (w_rd_en) begin
            r_d_out <= w_rd_word[RAM_DATA_W-1:0];
        end
    end

    assign d_out = r_d_out;

endmodule : byte_ram
`default_nettype wire

// File: tb/tb_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_ram
// Description : Directed self-checking bench for byte_ram. A reference byte
//               model supplies expected read data; reads push an expected
//               entry into a queue that is popped when d_out updates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_ram;

    localparam int AW = 17;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          en_in;
    logic          r_nw_in;
    logic [AW-1:0] a_in;
    logic [7:0]    d_in;
    logic [7:0]    d_out;
    logic          parity_err_out;

    byte_ram #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .en_in          (en_in),
        .r_nw_in        (r_nw_in),
        .a_in           (a_in),
        .d_in           (d_in),
        .d_out          (d_out),
        .parity_err_out (parity_err_out)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] model [int];
    exp_t       exp_q [$];
    logic [7:0] held_d;
    logic       held_p;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns after the
    // rising edge. Reads are checked via the queue; other cycles check hold.
    task automatic step(input string tag, input logic en, input logic rnw,
                        input logic [AW-1:0] a, input logic [7:0] d,
                        input logic perr_exp);
        exp_t e;
        en_in   = en;
        r_nw_in = rnw;
        a_in    = a;
        d_in    = d;
        if (en && rnw) begin
            e.data = model.exists(int'(a)) ? model[int'(a)] : 8'hxx;
            e.perr = perr_exp;
            exp_q.push_back(e);
        end
        if (en && !rnw && rst_n_in) model[int'(a)] = d;
        @(posedge clk_in);
        #1;
        if (en && rnw) begin
            e = exp_q.pop_front();
            chk8({tag, "_data"}, d_out, e.data);
            chk1({tag, "_perr"}, parity_err_out, e.perr);
            held_d = e.data;
            held_p = e.perr;
        end else begin
            chk8({tag, "_hold"}, d_out, held_d);
            chk1({tag, "_hold_perr"}, parity_err_out, held_p);
        end
        @(negedge clk_in);
    endtask

    initial begin
        rst_n_in = 1'b0;
        en_in    = 1'b0;
        r_nw_in  = 1'b1;
        a_in     = '0;
        d_in     = '0;
        held_d   = 8'h00;
        held_p   = 1'b0;
        #1;
        chk8("reset_dout", d_out, 8'h00);
        chk1("reset_perr", parity_err_out, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Idle after reset keeps zero.
        step("idle0", 1'b0, 1'b1, 17'h00010, 8'h00, 1'b0);

        // Single write then read of the same address on the next cycle.
        step("wr_a5", 1'b1, 1'b0, 17'h00010, 8'hA5, 1'b0);
        step("rd_a5", 1'b1, 1'b1, 17'h00010, 8'h00, 1'b0);

        // Address extremes, checking for aliasing.
        step("wr_top", 1'b1, 1'b0, 17'h1FFFF, 8'h3C, 1'b0);
        step("wr_bot", 1'b1, 1'b0, 17'h00000, 8'hC3, 1'b0);
        step("rd_top", 1'b1, 1'b1, 17'h1FFFF, 8'h00, 1'b0);
        step("rd_bot", 1'b1, 1'b1, 17'h00000, 8'h00, 1'b0);

        // Enable gating: a disabled "write" must not land.
        step("wr_11",   1'b1, 1'b0, 17'h00005, 8'h11, 1'b0);
        step("rd_11a",  1'b1, 1'b1, 17'h00010, 8'h00, 1'b0);
        step("gate_wr", 1'b0, 1'b0, 17'h00005, 8'hFF, 1'b0);
        step("gate_rd", 1'b0, 1'b1, 17'h1FFFF, 8'hFF, 1'b0);
        step("rd_11b",  1'b1, 1'b1, 17'h00005, 8'h00, 1'b0);

        // Burst: 256 writes, then 256 back-to-back reads with no bubbles.
        for (int i = 0; i < 256; i++) begin
            step("burst_wr", 1'b1, 1'b0, AW'(i), 8'(i), 1'b0);
        end
        for (int i = 0; i < 256; i++) begin
            step("burst_rd", 1'b1, 1'b1, AW'(i), 8'h00, 1'b0);
        end
        chk1("burst_q_empty", exp_q.size() == 0, 1'b1);

        // Reset mid-run: async clear of the outputs, writes ignored,
        // array contents survive.
        en_in   = 1'b1;
        r_nw_in = 1'b0;
        a_in    = 17'h00010;
        d_in    = 8'hEE;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk8("mid_reset_dout", d_out, 8'h00);
        chk1("mid_reset_perr", parity_err_out, 1'b0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        held_d   = 8'h00;
        held_p   = 1'b0;
        step("post_rst_idle", 1'b0, 1'b1, 17'h00010, 8'h00, 1'b0);
        step("post_rst_rd",   1'b1, 1'b1, 17'h00010, 8'h00, 1'b0);
        step("post_rst_rd2",  1'b1, 1'b1, 17'h1FFFF, 8'h00, 1'b0);

`ifdef RAM_PARITY_EN
        // Corrupt one stored data bit behind the RAM's back.
        dut.r_mem[17'h00020][0] = ~dut.r_mem[17'h00020][0];
        model[32'h20] = model[32'h20] ^ 8'h01;
        step("par_bad",   1'b1, 1'b1, 17'h00020, 8'h00, 1'b1);
        step("par_clean", 1'b1, 1'b1, 17'h00021, 8'h00, 1'b0);
        step("par_fix",   1'b1, 1'b0, 17'h00020, 8'h5A, 1'b0);
        step("par_hold",  1'b0, 1'b1, 17'h00020, 8'h00, 1'b0);
        step("par_rd_ok", 1'b1, 1'b1, 17'h00020, 8'h00, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_byte_ram
`default_nettype wire
